// File: rtl/fpu_cvt_pkg.sv
// fpu_cvt_pkg: shared constants and pipeline stage types for the ftoi arbiter
package fpu_cvt_pkg;
  localparam int EXP_BIAS = 127;
  localparam logic [7:0] EXP_SPECIAL = 8'd255;
  localparam logic [7:0] EXP_I32_OVF = 8'd158;
  localparam logic [31:0] F32_INT_MIN = 32'hCF000000;
  localparam int ID_W_MAX = 4;
  typedef struct packed {
    logic [31:0] x;
    logic [ID_W_MAX-1:0] id;
  } cvt_s1_t;
  typedef struct packed {
    logic [31:0] y;
    logic [ID_W_MAX-1:0] id;
    logic exc;
  } cvt_s2_t;
endpackage

// File: rtl/fpu_cvt_arbiter_rr.sv
// rr_arbiter: circular first-valid search starting at ptr, grant gated by enable
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);
  logic found;
  int j;
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && valid_i[j]) begin
        found = 1'b1;
        idx_o = IW'(j);
      end
    end
    grant_o = (found && en_i) ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/ftoi.sv
// ftoi: IEEE-754 single to signed 32-bit integer, round to nearest ties away, saturating
module ftoi (
  input  logic [31:0] x,
  output logic [31:0] y
);
  logic [7:0] e, sh;
  logic [31:0] mant, mag;
  assign e = x[30:23];
  assign sh = 8'd150 - e;
  assign mant = {8'd0, 1'b1, x[22:0]};
  always_comb begin
    mag = '0;
    if (e >= 8'd158) mag = x[31] ? 32'h80000000 : 32'h7FFFFFFF;
    else if (e >= 8'd150) mag = mant << (e - 8'd150);
    else if (e >= 8'd126) mag = (mant + (32'd1 << (sh - 8'd1))) >> sh;
    y = (e >= 8'd158) ? mag : (x[31] ? -mag : mag);
  end
endmodule

// File: rtl/fpu_cvt_arbiter.sv
// fpu_cvt_arbiter: round-robin sharing of one ftoi across requesters, 2-stage backpressured pipeline
module fpu_cvt_arbiter
  import fpu_cvt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_x,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_y,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_exc,
  output logic              busy
);
  cvt_s1_t s1_q, s1_d;
  cvt_s2_t s2_q, s2_d;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [IDW-1:0] ptr_q, ptr_d, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic s1_en, s2_en, acc, exc;
  logic [31:0] y;
  assign s2_en = !s2_v_q || rsp_ready;
  assign s1_en = !s1_v_q || s2_en;
  // rst gates the grant so req_ready reads zero while reset is held
  rr_arbiter #(.N(NREQ)) u_arb (
    .valid_i(req_valid),
    .ptr_i  (ptr_q),
    .en_i   (s1_en && !rst),
    .grant_o(gnt),
    .idx_o  (gnt_idx)
  );
  assign req_ready = gnt;
  assign acc = |gnt;
  ftoi u_ftoi (
    .x(s1_q.x),
    .y(y)
  );
  assign exc = (s1_q.x[30:23] == EXP_SPECIAL) || (s1_q.x[30:23] >= EXP_I32_OVF && s1_q.x != F32_INT_MIN);
  always_comb begin
    s1_d = acc ? cvt_s1_t'{x: req_x[32*gnt_idx +: 32], id: ID_W_MAX'(gnt_idx)} : s1_q;
    s1_v_d = s1_en ? acc : s1_v_q;
    s2_d = (s2_en && s1_v_q) ? cvt_s2_t'{y: y, id: s1_q.id, exc: exc} : s2_q;
    s2_v_d = s2_en ? s1_v_q : s2_v_q;
    ptr_d = !acc ? ptr_q : (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      ptr_q <= ptr_d;
    end
  end
  assign rsp_valid = s2_v_q;
  assign rsp_y = s2_q.y;
  assign rsp_id = s2_q.id[IDW-1:0];
  assign rsp_exc = s2_q.exc;
  assign busy = s1_v_q || s2_v_q;
endmodule
